// File: rtl/reg_reader.sv
// reg_reader: operand fetch stage with a pending-write scoreboard.
//
// Reads two source operands from a flattened register file (general regs at
// indices 0-31, float regs at 32-63), forwards a same-cycle write onto the
// operands, and stalls while a source is reserved by an in-flight
// long-latency operation. Results are handed off through a valid/ready pair.
//
// Ports:
//   clk, rstn                      clock, async active-low reset
//   req_valid / req_ready          request handshake
//   rs{1,2}_gfflag, rs{1,2}_num    source selects (gfflag 1 = float)
//   regs                           flattened register file, WIDTH*NUM bits
//   wr_enable/gfflag/num/data      write being committed this cycle
//   mark_enable/gfflag/num         reserve a destination (sets pending)
//   out_valid / out_ready          operand handshake
//   rs1_data, rs2_data             registered operand values
//
// States:
//   EMPTY | no request held, ready for a new one
//   STALL | request held, waiting for a pending source to be written
//   FULL  | operands captured, presenting out_valid
module reg_reader #(
  parameter int WIDTH = 32,
  parameter int NUM   = 64
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 rs1_gfflag,
  input  logic                 rs2_gfflag,
  input  logic [4:0]           rs1_num,
  input  logic [4:0]           rs2_num,
  input  logic [WIDTH*NUM-1:0] regs,
  input  logic                 wr_enable,
  input  logic                 wr_gfflag,
  input  logic [4:0]           wr_num,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 mark_enable,
  input  logic                 mark_gfflag,
  input  logic [4:0]           mark_num,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     rs1_data,
  output logic [WIDTH-1:0]     rs2_data
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [NUM-1:0]   pending_q, pending_d;
  logic [5:0]       req1_q, req1_d, req2_q, req2_d;
  logic [WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d;

  logic [5:0] rs1_idx, rs2_idx, wr_idx, mark_idx;
  logic [5:0] sel1_idx, sel2_idx;
  logic       accept, hazard;

  assign rs1_idx  = {rs1_gfflag, rs1_num};
  assign rs2_idx  = {rs2_gfflag, rs2_num};
  assign wr_idx   = {wr_gfflag, wr_num};
  assign mark_idx = {mark_gfflag, mark_num};

  // Bypassed operand value; general register 0 always reads as zero.
  function automatic logic [WIDTH-1:0] operand(input logic [5:0] idx,
                                               input logic [WIDTH*NUM-1:0] rf,
                                               input logic we,
                                               input logic [5:0] widx,
                                               input logic [WIDTH-1:0] wdata);
    if (idx == 6'd0)                 return '0;
    else if (we && (widx == idx))    return wdata;
    else                             return rf[int'(idx)*WIDTH +: WIDTH];
  endfunction

  // A same-cycle write to a pending source resolves the hazard via bypass.
  function automatic logic src_hazard(input logic [5:0] idx,
                                      input logic [NUM-1:0] pend,
                                      input logic we,
                                      input logic [5:0] widx);
    return pend[idx] && !(we && (widx == idx));
  endfunction

  assign req_ready = rstn && ((state_q == ST_EMPTY) || ((state_q == ST_FULL) && out_ready));
  assign accept    = req_valid && req_ready;
  assign out_valid = (state_q == ST_FULL);
  assign rs1_data  = rs1_q;
  assign rs2_data  = rs2_q;

  // In STALL the held request is re-evaluated; otherwise the incoming one.
  assign sel1_idx = (state_q == ST_STALL) ? req1_q : rs1_idx;
  assign sel2_idx = (state_q == ST_STALL) ? req2_q : rs2_idx;
  assign hazard   = src_hazard(sel1_idx, pending_q, wr_enable, wr_idx) ||
                    src_hazard(sel2_idx, pending_q, wr_enable, wr_idx);

  always_comb begin
    pending_d = pending_q;
    if (wr_enable)
      pending_d[wr_idx] = 1'b0;
    // Mark after clear so a same-cycle mark+write leaves the bit set.
    if (mark_enable)
      pending_d[mark_idx] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    req1_d  = req1_q;
    req2_d  = req2_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    if (accept) begin
      req1_d = rs1_idx;
      req2_d = rs2_idx;
    end
    if (accept || (state_q == ST_STALL)) begin
      if (hazard) begin
        state_d = ST_STALL;
      end else begin
        state_d = ST_FULL;
        rs1_d   = operand(sel1_idx, regs, wr_enable, wr_idx, wr_data);
        rs2_d   = operand(sel2_idx, regs, wr_enable, wr_idx, wr_data);
      end
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_EMPTY;
      pending_q <= '0;
      req1_q    <= '0;
      req2_q    <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      req1_q    <= req1_d;
      req2_q    <= req2_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
    end
  end

endmodule

// File: doc/reg_reader.md
REG_READER -- requirements
Module: reg_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, register data width in bits.
REQ-002 SHALL have parameter NUM, default 64, register count: 32 general at indices 0-31, 32 float at indices 32-63.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  1  read request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when req_valid&&req_ready at a rising edge.
REQ-007 SHALL have ports rs1_gfflag, rs2_gfflag  input  1 each  0 = general, 1 = float.
REQ-008 SHALL have ports rs1_num, rs2_num  input  5 each  source register number.
REQ-009 SHALL have port regs  input  WIDTH*NUM  flattened register file; index k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-010 SHALL have ports wr_enable (1), wr_gfflag (1), wr_num (5), wr_data (WIDTH), all inputs  same-cycle register write being committed by the writer.
REQ-011 SHALL have ports mark_enable (1), mark_gfflag (1), mark_num (5), all inputs  reserve a destination for an in-flight long-latency operation.
REQ-012 SHALL have port out_valid  output  1  operand pair valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts operands.
REQ-014 SHALL have ports rs1_data, rs2_data  output  WIDTH each  registered operand values.

Function
REQ-015 SHALL form each 6-bit register index as {gfflag, num}.
REQ-016 SHALL hold a NUM-bit pending scoreboard: mark_enable sets pending[idx]; wr_enable clears pending[idx]; mark and write on the same idx in one cycle leave the bit set.
REQ-017 SHALL ignore mark_enable on general register 0; pending[0] SHALL always be 0.
REQ-018 SHALL return 0 for general register 0 regardless of regs or writes.
REQ-019 SHALL resolve each operand as wr_data if wr_enable and the wr idx equals the source idx (nonzero idx, or any float idx), else the regs slice (write bypass).
REQ-020 SHALL treat a source as hazarded when its pending bit is 1 and no write to that idx occurs in the same cycle.
REQ-021 SHALL implement states EMPTY, STALL and FULL; reset state is EMPTY.
REQ-022 SHALL drive req_ready = (state==EMPTY) || (state==FULL && out_ready); req_ready SHALL be 0 in STALL.
REQ-023 SHALL latch rs1/rs2 idx into an internal request register on acceptance.
REQ-024 SHALL, on acceptance without hazard, capture both bypassed operands at that edge and enter FULL; out_valid rises the next cycle (latency 1).
REQ-025 SHALL, on acceptance with hazard on either source, enter STALL.
REQ-026 SHALL, in STALL, re-evaluate the hazard every cycle using the latched indices; on the first cycle without hazard, capture the bypassed operands and enter FULL.
REQ-027 SHALL, in FULL, hold out_valid=1 and rs1_data/rs2_data stable until out_valid&&out_ready.
REQ-028 SHALL, in FULL with out_ready and a new accepted request, follow REQ-024/025 for the new request, giving back-to-back throughput of one per cycle.
REQ-029 SHALL, in FULL with out_ready and no new request, return to EMPTY and deassert out_valid.
REQ-030 SHALL let scoreboard updates proceed every cycle independent of state.
REQ-031 SHALL treat rs1 idx == rs2 idx as legal; both outputs carry the same value.

Reset
REQ-032 SHALL, while rstn=0, force state EMPTY, pending all 0, out_valid 0, rs1_data 0, rs2_data 0, req_ready 0.
REQ-033 SHALL, on reset mid-STALL or mid-FULL, discard the held request without emitting it.
REQ-034 SHALL restore req_ready=1 in the first cycle after rstn deasserts.

Verification
REQ-035 SHALL verify basic read: regs[g5]=0x11, regs[f3 (idx 35)]=0x22, request rs1=g5, rs2=f3 -> next cycle out_valid=1, rs1_data=0x11, rs2_data=0x22.
REQ-036 SHALL verify bypass: regs[g7]=0x1, wr g7=0xAB in the accept cycle -> rs1_data=0xAB; request rs1=g0 with wr g0=0x5 -> rs1_data=0.
REQ-037 SHALL verify stall: mark f1, then request rs1=f1 -> STALL, req_ready=0 for 3 cycles; wr f1=0x3F800000 -> out_valid next cycle, data 0x3F800000, pending[33]=0.
REQ-038 SHALL verify backpressure: out_ready=0 for 4 cycles -> data stable, req_ready=0; then out_ready=1 with a new request -> a new result appears next cycle with no bubble.
REQ-039 SHALL verify a simultaneous mark+write on g9 -> pending[9]=1 and a request on g9 stalls.
REQ-040 SHALL verify reset asserted during STALL -> out_valid=0, pending=0, and no stale result appears after release.
